// File: rtl/gpio_pkg.sv
// Shared widths and DIN field layout for the GPIO input conditioner.
package gpio_pkg;
   localparam int N_SW    = 14;
   localparam int N_KEY   = 3;
   localparam int DIN_W   = 17;
   localparam int SW_LSB  = 0;
   localparam int KEY_LSB = 14;
endpackage

// File: rtl/debounce_bit.sv
// One raw input: 2-FF synchroniser followed by a tick-paced stability debouncer.
module debounce_bit #(
   parameter logic RST_VAL      = 1'b0,
   parameter int   STABLE_TICKS = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic tick,
   input  logic raw,
   output logic deb
);
   localparam int             CW       = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
         cnt   <= '0;
         deb   <= RST_VAL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // cnt counts consecutive ticks on which the input disagreed with deb
         if (tick) begin
            if (sync2 == deb) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               deb <= sync2;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end
endmodule

// File: rtl/gpio_input_conditioner.sv
// Synchronises and debounces switches/buttons, latches key presses as sticky flags.
module gpio_input_conditioner
   import gpio_pkg::*;
#(
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [N_SW-1:0]  SW,
   input  logic [N_KEY-1:0] KEY,
   input  logic [N_KEY-1:0] key_clr,
   output logic [DIN_W-1:0] DIN,
   output logic             key_irq
);
   localparam int            PW     = $clog2(TICK_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]    pcnt;
   logic             tick;
   logic [N_SW-1:0]  sw_deb;
   logic [N_KEY-1:0] key_deb;
   logic [N_KEY-1:0] key_deb_prev;
   logic [N_KEY-1:0] press;
   logic [N_KEY-1:0] key_flags;
   logic [N_KEY-1:0] flags_next;

   assign tick = (pcnt == P_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) pcnt <= '0;
      else        pcnt <= tick ? '0 : pcnt + PW'(1);
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_bit #(.RST_VAL(1'b0), .STABLE_TICKS(STABLE_TICKS)) u_deb (
         .CLK(CLK), .RST_N(RST_N), .tick(tick), .raw(SW[i]), .deb(sw_deb[i])
      );
   end

   for (genvar i = 0; i < N_KEY; i++) begin : g_key
      debounce_bit #(.RST_VAL(1'b1), .STABLE_TICKS(STABLE_TICKS)) u_deb (
         .CLK(CLK), .RST_N(RST_N), .tick(tick), .raw(KEY[i]), .deb(key_deb[i])
      );
   end

   // Keys are active-low: a press is the debounced 1->0 transition. Set beats clear.
   assign press      = key_deb_prev & ~key_deb;
   assign flags_next = (key_flags & ~key_clr) | press;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         key_deb_prev <= '1;
         key_flags    <= '0;
         key_irq      <= 1'b0;
      end else begin
         key_deb_prev <= key_deb;
         key_flags    <= flags_next;
         key_irq      <= |flags_next;
      end
   end

   assign DIN[SW_LSB  +: N_SW]  = sw_deb;
   assign DIN[KEY_LSB +: N_KEY] = key_flags;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed and randomized checks of the input conditioner against a behavioural model.
module tb_gpio_input_conditioner;
   localparam int TD = 4;
   localparam int ST = 3;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [13:0] SW;
   logic [2:0]  KEY;
   logic [2:0]  key_clr;
   logic [16:0] DIN;
   logic        key_irq;

   int checks = 0;
   int errors = 0;

   gpio_input_conditioner #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .CLK(CLK), .RST_N(RST_N), .SW(SW), .KEY(KEY), .key_clr(key_clr),
      .DIN(DIN), .key_irq(key_irq)
   );

   always #5 CLK = ~CLK;

   // Model: raw samples from the last two edges, edges since reset, per-bit run lengths.
   logic [16:0] raw_q[$];
   logic [16:0] m_deb;
   int          run[17];
   int          edges;
   logic [2:0]  m_d1, m_d2;
   logic [2:0]  m_flags;
   logic [13:0] cur_sw;

   function automatic void model_reset();
      raw_q   = '{17'h1C000, 17'h1C000};
      m_deb   = 17'h1C000;
      foreach (run[b]) run[b] = 0;
      edges   = 0;
      m_d1    = 3'b111;
      m_d2    = 3'b111;
      m_flags = 3'b000;
   endfunction

   task automatic step(input logic [13:0] sw, input logic [2:0] key,
                       input logic [2:0] clr, input logic rst);
      logic [16:0] s;
      SW = sw; KEY = key; key_clr = clr; RST_N = rst;
      if (!rst) model_reset();
      @(posedge CLK);
      if (rst) begin
         edges++;
         m_flags = (m_flags & ~clr) | (m_d2 & ~m_d1);
         s = raw_q.pop_front();
         raw_q.push_back({key, sw});
         if (edges % TD == 0) begin
            for (int b = 0; b < 17; b++) begin
               if (s[b] != m_deb[b]) begin
                  run[b]++;
                  if (run[b] == ST) begin
                     m_deb[b] = s[b];
                     run[b]   = 0;
                  end
               end else begin
                  run[b] = 0;
               end
            end
         end
         m_d2 = m_d1;
         m_d1 = m_deb[16:14];
      end
      #1;
   endtask

   task automatic settle(input logic [13:0] sw);
      cur_sw = sw;
      for (int n = 0; n < 20; n++) step(sw, 3'b111, 3'b000, 1'b1);
      step(sw, 3'b111, 3'b111, 1'b1);
      for (int n = 0; n < 2; n++) step(sw, 3'b111, 3'b000, 1'b1);
   endtask

   task automatic test_reset();
      int hit = -1;
      for (int n = 0; n < 5; n++) begin
         step(14'h3FFF, 3'b000, 3'b000, 1'b0);
         checks++;
         if (DIN !== 17'h0 || key_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: DIN=%h irq=%b, want DIN=00000 irq=0", DIN, key_irq);
         end
      end
      for (int n = 1; n <= 16; n++) begin
         step(14'h3FFF, 3'b000, 3'b000, 1'b1);
         checks++;
         if (DIN !== {m_flags, m_deb[13:0]} || key_irq !== |m_flags) begin
            errors++;
            $display("FAIL reset_model: DIN=%h irq=%b, want DIN=%h irq=%b",
                     DIN, key_irq, {m_flags, m_deb[13:0]}, |m_flags);
         end
         if (hit < 0 && DIN[13:0] === 14'h3FFF) hit = n;
      end
      checks++;
      if (hit < 0 || hit > 14) begin
         errors++;
         $display("FAIL reset_release_latency: switches seen after %0d cycles, want <= 14", hit);
      end
   endtask

   task automatic test_switch();
      int hit = -1;
      settle(14'h0000);
      for (int n = 1; n <= 20; n++) begin
         step(14'h0001, 3'b111, 3'b000, 1'b1);
         checks++;
         if (DIN !== {m_flags, m_deb[13:0]}) begin
            errors++;
            $display("FAIL switch_model: DIN=%h, want %h", DIN, {m_flags, m_deb[13:0]});
         end
         if (hit < 0 && DIN[0] === 1'b1) hit = n;
      end
      checks++;
      if (hit < 0 || hit > 14) begin
         errors++;
         $display("FAIL switch_latency: DIN[0] rose after %0d cycles, want <= 14", hit);
      end
      for (int n = 0; n < 5; n++) step(14'h0003, 3'b111, 3'b000, 1'b1);
      for (int n = 0; n < 20; n++) begin
         step(14'h0001, 3'b111, 3'b000, 1'b1);
         checks++;
         if (DIN[1] !== 1'b0) begin
            errors++;
            $display("FAIL switch_glitch: DIN[1]=%b, want 0", DIN[1]);
         end
      end
      cur_sw = 14'h0001;
   endtask

   task automatic test_key_press();
      settle(cur_sw);
      for (int n = 0; n < 20; n++) step(cur_sw, 3'b011, 3'b000, 1'b1);
      for (int n = 0; n < 20; n++) begin
         step(cur_sw, 3'b111, 3'b000, 1'b1);
         checks++;
         if (DIN !== {m_flags, m_deb[13:0]} || key_irq !== |m_flags) begin
            errors++;
            $display("FAIL key_model: DIN=%h irq=%b, want DIN=%h irq=%b",
                     DIN, key_irq, {m_flags, m_deb[13:0]}, |m_flags);
         end
      end
      checks++;
      if (DIN[16] !== 1'b1 || key_irq !== 1'b1) begin
         errors++;
         $display("FAIL key_sticky: DIN[16]=%b irq=%b, want 1 1", DIN[16], key_irq);
      end
      step(cur_sw, 3'b111, 3'b100, 1'b1);
      checks++;
      if (DIN[16] !== 1'b0 || key_irq !== 1'b0) begin
         errors++;
         $display("FAIL key_clear: DIN[16]=%b irq=%b, want 0 0", DIN[16], key_irq);
      end
      step(cur_sw, 3'b111, 3'b000, 1'b1);
      checks++;
      if (DIN[16] !== 1'b0 || key_irq !== 1'b0) begin
         errors++;
         $display("FAIL key_clear_hold: DIN[16]=%b irq=%b, want 0 0", DIN[16], key_irq);
      end
   endtask

   task automatic test_set_clear();
      bit found = 0;
      settle(cur_sw);
      for (int n = 0; n < 40 && !found; n++) begin
         if (m_d2[0] && !m_d1[0]) begin
            step(cur_sw, 3'b110, 3'b001, 1'b1);
            found = 1;
         end else begin
            step(cur_sw, 3'b110, 3'b000, 1'b1);
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL set_clear_timeout: press never fired, want within 40 cycles");
      end
      checks++;
      if (DIN[14] !== 1'b1 || key_irq !== 1'b1) begin
         errors++;
         $display("FAIL set_clear: DIN[14]=%b irq=%b, want 1 1", DIN[14], key_irq);
      end
      step(cur_sw, 3'b110, 3'b000, 1'b1);
      checks++;
      if (DIN[14] !== 1'b1) begin
         errors++;
         $display("FAIL set_clear_hold: DIN[14]=%b, want 1", DIN[14]);
      end
   endtask

   task automatic test_reset_mid();
      settle(14'h0000);
      for (int n = 0; n < 6; n++) step(14'h0008, 3'b111, 3'b000, 1'b1);
      for (int n = 0; n < 3; n++) step(14'h0008, 3'b111, 3'b000, 1'b0);
      step(14'h0008, 3'b111, 3'b000, 1'b1);
      checks++;
      if (DIN[3] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_sw: DIN[3]=%b, want 0", DIN[3]);
      end
      settle(14'h0000);
      for (int n = 0; n < 20; n++) step(cur_sw, 3'b101, 3'b000, 1'b1);
      for (int n = 0; n < 4; n++) begin
         step(cur_sw, 3'b101, 3'b000, 1'b0);
         checks++;
         if (DIN[15] !== 1'b0 || key_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_key: DIN[15]=%b irq=%b, want 0 0", DIN[15], key_irq);
         end
      end
      step(cur_sw, 3'b111, 3'b000, 1'b0);
      for (int n = 0; n < 20; n++) begin
         step(cur_sw, 3'b111, 3'b000, 1'b1);
         checks++;
         if (DIN[15] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_event: DIN[15]=%b, want 0", DIN[15]);
         end
      end
      for (int n = 0; n < 20; n++) step(cur_sw, 3'b101, 3'b000, 1'b1);
      checks++;
      if (DIN[15] !== 1'b1 || key_irq !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_fresh_press: DIN[15]=%b irq=%b, want 1 1", DIN[15], key_irq);
      end
   endtask

   task automatic test_random();
      logic [13:0] sw;
      logic [2:0]  key, clr;
      int          len;
      for (int seg = 0; seg < 200; seg++) begin
         sw  = ($urandom_range(0, 1) == 0) ? cur_sw : 14'($urandom);
         key = 3'($urandom);
         len = $urandom_range(1, 20);
         if ($urandom_range(0, 39) == 0) begin
            for (int n = 0; n < 2; n++) begin
               step(sw, key, 3'b000, 1'b0);
               checks++;
               if (DIN !== 17'h0 || key_irq !== 1'b0) begin
                  errors++;
                  $display("FAIL random_reset: DIN=%h irq=%b, want 00000 0", DIN, key_irq);
               end
            end
         end
         for (int n = 0; n < len; n++) begin
            clr = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            step(sw, key, clr, 1'b1);
            checks++;
            if (DIN !== {m_flags, m_deb[13:0]} || key_irq !== |m_flags) begin
               errors++;
               $display("FAIL random_model: DIN=%h irq=%b, want DIN=%h irq=%b",
                        DIN, key_irq, {m_flags, m_deb[13:0]}, |m_flags);
            end
         end
         cur_sw = sw;
      end
   endtask

   initial begin
      SW = '0; KEY = 3'b111; key_clr = '0; RST_N = 1'b0;
      cur_sw = '0;
      model_reset();
      test_reset();
      test_switch();
      test_key_press();
      test_set_clear();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Conditions the raw board inputs (slide switches and push-buttons) before they reach the GPIO peripheral's 17-bit `DIN` input. The block does four things:
- synchronises every asynchronous pin into `CLK`;
- debounces each bit against a shared millisecond tick;
- turns push-button presses into sticky event flags that software clears explicitly;
- presents the result as `DIN = {key_flags[2:0], sw_deb[13:0]}` to the GPIO read path.

## Interface
Parameters:
- `TICK_DIV`, 50000, `CLK` cycles per debounce tick (1 ms at 50 MHz); must be ≥ 2.
- `STABLE_TICKS`, 4, consecutive ticks an input must differ from its debounced value before it is accepted; must be ≥ 1.

Ports (reset `RST_N`, asynchronous, active-low; clock `CLK`):
- `CLK`  in  1  system clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `SW`  in  14  raw slide switches, asynchronous, active-high.
- `KEY`  in  3  raw push-buttons, asynchronous, active-low (released = 1).
- `key_clr`  in  3  per-bit clear of the sticky key flags; a 1-cycle pulse, synchronous.
- `DIN`  out  17  `{key_flags[2:0], sw_deb[13:0]}`; driven directly from registers.
- `key_irq`  out  1  OR of `key_flags`; driven from a register.

## Operation
- **Synchroniser.** Each input passes through a 2-FF synchroniser. Reset values: `SW` stages 0, `KEY` stages 1.
- **Prescaler.** Counter `0..TICK_DIV-1`, reset to 0, wraps to 0. `tick` is high for 1 cycle when the count equals `TICK_DIV-1`.
- **Per-bit debouncer.** Holds `deb` and a stability counter `cnt` (width `$clog2(STABLE_TICKS+1)`, reset 0). On each `tick` cycle:
  - sync == `deb`: `cnt` ← 0.
  - sync ≠ `deb` and `cnt` == `STABLE_TICKS-1`: `deb` ← sync, `cnt` ← 0.
  - sync ≠ `deb` otherwise: `cnt` ← `cnt`+1.
  - Outside tick cycles, `cnt` and `deb` hold.
  - Reset values: `SW` `deb` 0, `KEY` `deb` 1.
- **Press detection.** `press[i]` = `deb_prev[i]` & ~`deb[i]`, where `deb_prev` is `deb` registered by 1 cycle (reset 1). Release (0→1) produces no event.
- **Sticky flags** (reset 0):
  - `press[i]`: flag ← 1.
  - `key_clr[i]` without `press[i]`: flag ← 0.
  - `press[i]` and `key_clr[i]` in the same cycle: flag ← 1. The set wins so no event is lost.
- **Output registers.**
  - `key_irq` ← |next flags; it tracks the flags with no extra delay.
  - `DIN[13:0]` = `sw_deb`; `DIN[16:14]` = `key_flags`.
  - Reset values: `DIN` = 0, `key_irq` = 0.
- **Reset mid-debounce.** Aborts any pending change. All state returns to its reset value; no press event is generated by reset.

## Timing
- **Synchroniser latency.** A raw edge is visible at the synchroniser output 2 cycles later.
- **Switch acceptance.** Once the synchronised value is stable, `deb` (and `DIN[13:0]`) updates on the `STABLE_TICKS`-th tick cycle after the change.
- **Worst-case switch latency.** 2 + `STABLE_TICKS`×`TICK_DIV` cycles from a raw edge to `DIN`.
- **Key latency.** The flag and `key_irq` rise 1 cycle after `deb` of the key falls.
- **Clear latency.** A `key_clr` pulse in cycle N makes the flag 0 from cycle N+1.
- **Glitch rejection.** A glitch that reverts before `STABLE_TICKS` consecutive ticks of difference is never propagated.
- **Flag persistence.** Repeated presses while a flag is set keep it at 1. There is no counter or overflow.

## Structure
- Package `gpio_pkg`:
  - constants `N_SW = 14`, `N_KEY = 3`, `DIN_W = 17`;
  - `localparam` `DIN` field offsets: `SW_LSB = 0`, `KEY_LSB = 14`.
- Sub-module `debounce_bit`:
  - contents: synchroniser, `cnt`, `deb`;
  - parameters: reset level, `STABLE_TICKS`;
  - instantiated `N_SW` + `N_KEY` times in a generate loop.
- The top level holds the prescaler, press detection, sticky flags and output registers.

## Test plan
All scenarios use `TICK_DIV=4`, `STABLE_TICKS=3`.
- **Reset.** Hold `RST_N`=0 with `SW`=14'h3FFF and `KEY`=3'b000 → `DIN`=17'h0 and `key_irq`=0 throughout. After release, `DIN[13:0]`=14'h3FFF within 2+12 cycles.
- **Switch debounce.** `SW[0]` 0→1 held → `DIN[0]`=1 no later than 14 cycles after the edge. A 5-cycle `SW[1]` pulse → `DIN[1]` stays 0.
- **Key press.**
  - `KEY[2]` held 0 for 20 cycles, then released → `DIN[16]`=1 and `key_irq`=1, and both remain 1 after release.
  - Pulse `key_clr`=3'b100 → `DIN[16]`=0 and `key_irq`=0 on the next cycle.
- **Simultaneous set and clear.** Force `key_clr[0]`=1 in the exact cycle `press[0]` fires → `DIN[14]`=1 afterwards.
- **Reset mid-operation.**
  - Assert `RST_N` 6 cycles after a `SW[3]` edge → `DIN[3]`=0 after reset.
  - Assert `RST_N` while `KEY[1]`=0 → `DIN[15]`=0 after reset. No flag is raised while `KEY[1]` stays 0. The flag sets only on a fresh release-then-press.
